load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 12 +
 rtl/load_store_unit.sv | 89 ++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: word-wide memory request/response bus between the LSU and memory
interface load_store_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_ready, mem_rdata);
   modport slave  (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer with alignment checks, lane steering and memory timeout
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              is_store,
   input  logic [2:0]        func3,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   load_store_unit_if.master bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
   state_t      state, state_n;
   logic        st_q;
   logic [2:0]  f3_q;
   logic [1:0]  a_q;
   logic [31:0] addr_q, wd_q, rd_q;
   logic [3:0]  be_q;
   logic [7:0]  cnt;
   logic        legal, mis;
   logic [3:0]  be_n;
   logic [31:0] wd_n, ld;
   logic [7:0]  b;
   logic [15:0] h;
   assign legal = is_store ? (func3 inside {3'b000, 3'b001, 3'b010})
                           : (func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   assign mis   = (func3[1:0] == 2'b01 && addr[0]) || (func3[1:0] == 2'b10 && addr[1:0] != 2'b00);
   assign be_n  = func3[1:0] == 2'b00 ? 4'b0001 << addr[1:0] :
                  func3[1:0] == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
   assign wd_n  = func3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                  func3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
   assign b     = bus.mem_rdata[{a_q, 3'b000} +: 8];
   assign h     = a_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
   assign ld    = f3_q[1:0] == 2'b00 ? {{24{b[7] & ~f3_q[2]}}, b} :
                  f3_q[1:0] == 2'b01 ? {{16{h[15] & ~f3_q[2]}}, h} : bus.mem_rdata;
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   // next state: reject bad requests straight to ERR, abort ACCESS after TIMEOUT unready cycles
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (req_valid) state_n = (legal && !mis) ? ACCESS : ERR;
         ACCESS:  if (bus.mem_ready) state_n = RESP;
                  else if (cnt == 8'(TIMEOUT - 1)) state_n = ERR;
         default: state_n = IDLE;
      endcase
   end
   // request capture, wait counter and registered load result
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st_q   <= 1'b0;
         f3_q   <= 3'b000;
         a_q    <= 2'b00;
         addr_q <= 32'h0;
         be_q   <= 4'h0;
         wd_q   <= 32'h0;
         rd_q   <= 32'h0;
         cnt    <= 8'h0;
      end else begin
         if (state == IDLE && req_valid) begin
            st_q   <= is_store;
            f3_q   <= func3;
            a_q    <= addr[1:0];
            addr_q <= {addr[31:2], 2'b00};
            be_q   <= be_n;
            wd_q   <= wd_n;
         end
         if (state != ACCESS)      cnt <= 8'h0;
         else if (!bus.mem_ready)  cnt <= cnt + 8'h1;
         if (state == ACCESS && bus.mem_ready) rd_q <= st_q ? 32'h0 : ld;
      end
   assign busy          = state != IDLE;
   assign done          = state == RESP || state == ERR;
   assign err           = state == ERR;
   assign rdata         = state == RESP ? rd_q : 32'h0;
   assign bus.mem_req   = state == ACCESS;
   assign bus.mem_we    = state == ACCESS && st_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_be    = be_q;
   assign bus.mem_wdata = wd_q;
endmodule
